// File: rtl/sdcard_cpu_master_if.sv
// rtl/sdcard_cpu_master_if.sv - host, response and glue req/ack channel bundle for sdcard_cpu_master
interface sdcard_cpu_master_if #(
    parameter int ADDR  = 32,
    parameter int DATA  = 32,
    parameter int CNT_W = 16
) ();
    logic                host_valid;
    logic                host_ready;
    logic [ADDR-1:0]     host_addr;
    logic                host_cmd;
    logic [2*DATA-1:0]   host_wdata;

    logic                resp_valid;
    logic                resp_ready;
    logic                resp_cmd;
    logic [2*DATA-1:0]   resp_rdata;

    logic                async_addr_req;
    logic                async_addr_ack;
    logic [ADDR-1:0]     async_addr;
    logic                async_cmd_req;
    logic                async_cmd_ack;
    logic                async_cmd;
    logic                async_data_out_req;
    logic                async_data_out_ack;
    logic [DATA-1:0]     async_data_out;
    logic                async_data_in_req;
    logic                async_data_in_ack;
    logic [DATA-1:0]     async_data_in;

    logic                timeout;
    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    rd_cnt;

    modport master (
        input  host_valid, host_addr, host_cmd, host_wdata,
        output host_ready,
        output resp_valid, resp_cmd, resp_rdata,
        input  resp_ready,
        output async_addr_req, async_addr,
        input  async_addr_ack,
        output async_cmd_req, async_cmd,
        input  async_cmd_ack,
        output async_data_out_req, async_data_out,
        input  async_data_out_ack,
        input  async_data_in_req, async_data_in,
        output async_data_in_ack,
        output timeout, wr_cnt, rd_cnt
    );

    modport slave (
        output host_valid, host_addr, host_cmd, host_wdata,
        input  host_ready,
        input  resp_valid, resp_cmd, resp_rdata,
        output resp_ready,
        input  async_addr_req, async_addr,
        output async_addr_ack,
        input  async_cmd_req, async_cmd,
        output async_cmd_ack,
        input  async_data_out_req, async_data_out,
        output async_data_out_ack,
        output async_data_in_req, async_data_in,
        input  async_data_in_ack,
        input  timeout, wr_cnt, rd_cnt
    );
endinterface

// File: rtl/sdcard_cpu_master.sv
// rtl/sdcard_cpu_master.sv - CPU-side initiator sequencing addr/cmd/data req/ack channels of the sdcard glue
module sdcard_cpu_master #(
    parameter int ADDR    = 32,
    parameter int DATA    = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    sdcard_cpu_master_if.master  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND_ADDR = 3'd1;
    localparam logic [2:0] S_SEND_CMD  = 3'd2;
    localparam logic [2:0] S_SEND_D0   = 3'd3;
    localparam logic [2:0] S_SEND_D1   = 3'd4;
    localparam logic [2:0] S_RECV_D0   = 3'd5;
    localparam logic [2:0] S_RECV_D1   = 3'd6;
    localparam logic [2:0] S_RESP      = 3'd7;

    localparam int              WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] W_LIMIT = WAIT_W'(TIMEOUT);

    logic [2:0]          r_state;
    logic [ADDR-1:0]     r_addr;
    logic                r_cmd;
    logic [2*DATA-1:0]   r_wdata;
    logic [2*DATA-1:0]   r_rdata;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic [CNT_W-1:0]    r_rd_cnt;

    logic                w_xfer;
    logic                w_busy;
    logic [WAIT_W-1:0]   w_wait_next;

    // Handshake outputs depend on the state register only, never on glue inputs.
    assign bus.host_ready         = (r_state == S_IDLE);
    assign bus.resp_valid         = (r_state == S_RESP);
    assign bus.resp_cmd           = r_cmd;
    assign bus.resp_rdata         = r_rdata;
    assign bus.async_addr_req     = (r_state == S_SEND_ADDR);
    assign bus.async_addr         = r_addr;
    assign bus.async_cmd_req      = (r_state == S_SEND_CMD);
    assign bus.async_cmd          = r_cmd;
    assign bus.async_data_out_req = (r_state == S_SEND_D0) || (r_state == S_SEND_D1);
    assign bus.async_data_out     = (r_state == S_SEND_D0) ? r_wdata[DATA-1:0] : r_wdata[2*DATA-1:DATA];
    assign bus.async_data_in_ack  = (r_state == S_RECV_D0) || (r_state == S_RECV_D1);
    assign bus.timeout            = r_timeout;
    assign bus.wr_cnt             = r_wr_cnt;
    assign bus.rd_cnt             = r_rd_cnt;

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_wait_next = r_wait + WAIT_W'(1);

    always_comb begin
        w_xfer = 1'b0;
        case (r_state)
            S_SEND_ADDR: w_xfer = bus.async_addr_ack;
            S_SEND_CMD:  w_xfer = bus.async_cmd_ack;
            S_SEND_D0,
            S_SEND_D1:   w_xfer = bus.async_data_out_ack;
            S_RECV_D0,
            S_RECV_D1:   w_xfer = bus.async_data_in_req;
            default:     w_xfer = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_cmd    <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.host_valid) begin
                        r_addr  <= bus.host_addr;
                        r_cmd   <= bus.host_cmd;
                        r_wdata <= bus.host_wdata;
                        r_rdata <= '0;
                        r_state <= S_SEND_ADDR;
                    end
                end
                S_SEND_ADDR: if (w_xfer) r_state <= S_SEND_CMD;
                S_SEND_CMD:  if (w_xfer) r_state <= r_cmd ? S_SEND_D0 : S_RECV_D0;
                S_SEND_D0:   if (w_xfer) r_state <= S_SEND_D1;
                S_SEND_D1:   if (w_xfer) r_state <= S_RESP;
                S_RECV_D0: begin
                    if (w_xfer) begin
                        r_rdata[DATA-1:0] <= bus.async_data_in;
                        r_state           <= S_RECV_D1;
                    end
                end
                S_RECV_D1: begin
                    if (w_xfer) begin
                        r_rdata[2*DATA-1:DATA] <= bus.async_data_in;
                        r_state                <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= S_IDLE;
                        if (r_cmd) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        else       r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall counter saturates at the limit; the flag only reports, it never aborts a transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_busy || w_xfer) begin
                r_wait <= '0;
            end else if (r_wait != W_LIMIT) begin
                r_wait <= w_wait_next;
                if ((TIMEOUT > 0) && (w_wait_next == W_LIMIT)) r_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdcard_cpu_master.sv
// tb/tb_sdcard_cpu_master.sv - directed and randomized self-checking bench for sdcard_cpu_master
module tb_sdcard_cpu_master;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sdcard_cpu_master_if #(.ADDR(32), .DATA(32), .CNT_W(16)) bus ();

    sdcard_cpu_master #(.ADDR(32), .DATA(32), .TIMEOUT(8), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int mdl_wr = 0;
    int mdl_rd = 0;
    bit spurious = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic dut_side(input int ch);
        case (ch)
            0:       return bus.async_addr_req;
            1:       return bus.async_cmd_req;
            2:       return bus.async_data_out_req;
            default: return bus.async_data_in_ack;
        endcase
    endfunction

    function automatic logic [3:0] all_hs();
        return {bus.async_addr_req, bus.async_cmd_req, bus.async_data_out_req, bus.async_data_in_ack};
    endfunction

    // Glue-side handshake on one channel; entered and left on a falling edge.
    task automatic handshake(input int ch, input int dly, input logic [31:0] din, output logic [31:0] seen);
        int guard = 0;
        seen = '0;
        while (!dut_side(ch) && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk($sformatf("ch%0d_side_up", ch), {63'd0, dut_side(ch)}, 64'd1);
        if (ch < 3) begin
            for (int i = 0; i < dly; i++) begin
                if (ch == 0) bus.async_data_in_req = spurious;
                @(negedge clock);
                chk($sformatf("ch%0d_req_held", ch), {63'd0, dut_side(ch)}, 64'd1);
                if (ch == 0 && spurious) chk("spurious_in_ack", {63'd0, bus.async_data_in_ack}, 64'd0);
            end
            bus.async_data_in_req = 1'b0;
            case (ch)
                0: begin bus.async_addr_ack = 1'b1; seen = bus.async_addr; end
                1: begin bus.async_cmd_ack = 1'b1; seen = {31'd0, bus.async_cmd}; end
                default: begin bus.async_data_out_ack = 1'b1; seen = bus.async_data_out; end
            endcase
            @(negedge clock);
            bus.async_addr_ack     = 1'b0;
            bus.async_cmd_ack      = 1'b0;
            bus.async_data_out_ack = 1'b0;
        end else begin
            for (int i = 0; i < dly; i++) begin
                @(negedge clock);
                chk("in_ack_held", {63'd0, bus.async_data_in_ack}, 64'd1);
            end
            bus.async_data_in_req = 1'b1;
            bus.async_data_in     = din;
            @(negedge clock);
            bus.async_data_in_req = 1'b0;
            bus.async_data_in     = $urandom;
        end
    endtask

    task automatic start_txn(input logic cmd, input logic [31:0] addr, input logic [63:0] wdata, output int c0);
        int guard = 0;
        while (!bus.host_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("host_ready_idle", {63'd0, bus.host_ready}, 64'd1);
        bus.host_valid = 1'b1;
        bus.host_cmd   = cmd;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        c0 = cyc;
        @(negedge clock);
        bus.host_valid = 1'b0;
        bus.host_cmd   = ~cmd;
        bus.host_addr  = $urandom;
        bus.host_wdata = {$urandom, $urandom};
        chk("host_ready_busy", {63'd0, bus.host_ready}, 64'd0);
    endtask

    task automatic run_txn(input logic cmd, input logic [31:0] addr, input logic [63:0] wdata,
                           input int d0, input int d1, input int d2, input int d3,
                           input logic [31:0] w0, input logic [31:0] w1, input int hold, input bit chk_lat);
        int c0;
        int guard = 0;
        logic [31:0] s;
        logic [63:0] exp_rd;
        start_txn(cmd, addr, wdata, c0);
        handshake(0, d0, 32'd0, s);
        chk("async_addr", {32'd0, s}, {32'd0, addr});
        handshake(1, d1, 32'd0, s);
        chk("async_cmd", {32'd0, s}, {63'd0, cmd});
        if (cmd) begin
            handshake(2, d2, 32'd0, s);
            chk("data_out_w0", {32'd0, s}, {32'd0, wdata[31:0]});
            handshake(2, d3, 32'd0, s);
            chk("data_out_w1", {32'd0, s}, {32'd0, wdata[63:32]});
        end else begin
            handshake(3, d2, w0, s);
            handshake(3, d3, w1, s);
        end
        while (!bus.resp_valid && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("resp_valid_up", {63'd0, bus.resp_valid}, 64'd1);
        if (chk_lat) chk("latency", 64'(cyc - c0), 64'd5);
        exp_rd = cmd ? 64'd0 : {w1, w0};
        chk("resp_cmd", {63'd0, bus.resp_cmd}, {63'd0, cmd});
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("hold_rdata", bus.resp_rdata, exp_rd);
            chk("hold_host_ready", {63'd0, bus.host_ready}, 64'd0);
            chk("hold_no_req", {60'd0, all_hs()}, 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        bus.resp_ready = 1'b0;
        if (cmd) mdl_wr++; else mdl_rd++;
        chk("back_idle", {63'd0, bus.host_ready}, 64'd1);
        chk("resp_valid_down", {63'd0, bus.resp_valid}, 64'd0);
        chk("wr_cnt", {48'd0, bus.wr_cnt}, 64'(mdl_wr % 65536));
        chk("rd_cnt", {48'd0, bus.rd_cnt}, 64'(mdl_rd % 65536));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_host_ready"}, {63'd0, bus.host_ready}, 64'd1);
        chk({tag, "_resp_valid"}, {63'd0, bus.resp_valid}, 64'd0);
        chk({tag, "_handshakes"}, {60'd0, all_hs()}, 64'd0);
        chk({tag, "_timeout"}, {63'd0, bus.timeout}, 64'd0);
        chk({tag, "_wr_cnt"}, {48'd0, bus.wr_cnt}, 64'd0);
        chk({tag, "_rd_cnt"}, {48'd0, bus.rd_cnt}, 64'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 64'd0);
        chk({tag, "_addr"}, {32'd0, bus.async_addr}, 64'd0);
        chk({tag, "_cmd"}, {63'd0, bus.async_cmd}, 64'd0);
        chk({tag, "_data_out"}, {32'd0, bus.async_data_out}, 64'd0);
    endtask

    initial begin
        int c0;
        logic [31:0] s;
        logic        rc;
        logic [31:0] ra;
        logic [63:0] rw;
        int          dl [4];
        int          hd;

        reset = 1'b1;
        bus.host_valid = 1'b0;
        bus.host_addr  = '0;
        bus.host_cmd   = 1'b0;
        bus.host_wdata = '0;
        bus.resp_ready = 1'b0;
        bus.async_addr_ack     = 1'b0;
        bus.async_cmd_ack      = 1'b0;
        bus.async_data_out_ack = 1'b0;
        bus.async_data_in_req  = 1'b0;
        bus.async_data_in      = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_state("reset");

        run_txn(1'b1, 32'h100, 64'hAAAA_BBBB_1111_2222, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1'b1);
        run_txn(1'b0, 32'h40, 64'd0, 0, 0, 20, 0, 32'hDEAD_0001, 32'hBEEF_0002, 0, 1'b0);
        run_txn(1'b0, 32'h1234_5678, 64'd0, 0, 0, 0, 0, 32'h0BAD_F00D, 32'hCAFE_0001, 0, 1'b1);
        run_txn(1'b0, $urandom, 64'd0, 1, 2, 1, 1, $urandom, $urandom, 10, 1'b0);

        spurious = 1'b1;
        run_txn(1'b1, 32'h2000, {$urandom, $urandom}, 3, 0, 0, 0, 32'd0, 32'd0, 0, 1'b0);
        spurious = 1'b0;

        for (int n = 0; n < 24; n++) begin
            rc = 1'($urandom_range(0, 1));
            ra = $urandom;
            rw = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) dl[k] = (n < 4) ? 0 : $urandom_range(0, 4);
            hd = $urandom_range(0, 3);
            run_txn(rc, ra, rw, dl[0], dl[1], dl[2], dl[3], $urandom, $urandom, hd,
                    (dl[0] + dl[1] + dl[2] + dl[3]) == 0);
        end

        start_txn(1'b0, 32'h80, 64'd0, c0);
        handshake(0, 0, 32'd0, s);
        handshake(1, 0, 32'd0, s);
        chk("in_recv_d0", {63'd0, bus.async_data_in_ack}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mdl_wr = 0;
        mdl_rd = 0;
        check_reset_state("mid_reset");
        run_txn(1'b1, 32'h300, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1'b1);

        run_txn(1'b1, $urandom, {$urandom, $urandom}, 7, 0, 0, 0, 32'd0, 32'd0, 0, 1'b0);
        chk("timeout_below", {63'd0, bus.timeout}, 64'd0);
        run_txn(1'b0, $urandom, 64'd0, 9, 0, 0, 0, $urandom, $urandom, 0, 1'b0);
        chk("timeout_set", {63'd0, bus.timeout}, 64'd1);
        run_txn(1'b1, $urandom, {$urandom, $urandom}, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1'b1);
        chk("timeout_sticky", {63'd0, bus.timeout}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
